// File: rtl/axis_user_mux_if.sv
// AXI-Stream link used by axis_user_mux for both source ports and the merged output.
// Also carries the data-link status type shared by the mux and its environment.

package axis_user_mux_pkg;
    typedef enum logic [1:0] {
        DL_INACTIVE = 2'd0,
        DL_FEATURE  = 2'd1,
        DL_INIT     = 2'd2,
        DL_ACTIVE   = 2'd3
    } pcie_dl_status_e;
endpackage

interface axis_user_mux_if #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 2
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tready;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_user_mux.sv
// axis_user_mux: merges a DLLP stream and a TLP stream into one AXI-Stream output.
// Packet-atomic arbitration (decide in IDLE, then stream), DLLP priority, TLPs only
// granted while the link is DL_ACTIVE, tuser[1:0] rewritten with the source tag, and
// a 2-entry skid register on the output.
// Optional feature: define AXIS_USER_MUX_FAIR_ARB_EN to enable the DLLP burst limiter
// that forces a TLP grant after MAX_DLLP_BURST DLLP packets while a TLP is waiting.

module axis_user_mux
    import axis_user_mux_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int USER_WIDTH     = 2,
    parameter int MAX_DLLP_BURST = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  pcie_dl_status_e link_status_i,
    axis_user_mux_if.slave  s_tlp_axis,
    axis_user_mux_if.slave  s_dllp_axis,
    axis_user_mux_if.master m_axis
);

    if (USER_WIDTH < 2 || MAX_DLLP_BURST < 1) begin : g_param_check
        $error("axis_user_mux: USER_WIDTH must be >= 2 and MAX_DLLP_BURST >= 1");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_DLLP, ST_TLP} state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
        logic [USER_WIDTH-1:0] user;
    } beat_t;

    state_e state_q, state_d;

    beat_t  out_q, out_d, skid_q, skid_d, in_beat;
    logic   out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    logic   in_vld, in_rdy, push, pop;

    logic   tlp_ok, burst_full, pick_tlp, pick_dllp;

    // A TLP is only eligible for a new grant while the data link is up
    assign tlp_ok = s_tlp_axis.tvalid && (link_status_i == DL_ACTIVE);

`ifdef AXIS_USER_MUX_FAIR_ARB_EN
    localparam int CNT_W = $clog2(MAX_DLLP_BURST + 1);

    logic [CNT_W-1:0] dllp_burst_cnt_q;

    assign burst_full = (dllp_burst_cnt_q == CNT_W'(MAX_DLLP_BURST));

    // Count DLLP packets granted while a TLP waits; any TLP grant or idle TLP source clears it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dllp_burst_cnt_q <= '0;
        end else if (!s_tlp_axis.tvalid) begin
            dllp_burst_cnt_q <= '0;
        end else if (state_q == ST_IDLE && pick_tlp) begin
            dllp_burst_cnt_q <= '0;
        end else if (state_q == ST_IDLE && pick_dllp && !burst_full) begin
            dllp_burst_cnt_q <= dllp_burst_cnt_q + 1'b1;
        end
    end
`else
    assign burst_full = 1'b0;
`endif

    // DLLP wins ties unless the burst limit has been reached
    assign pick_tlp  = tlp_ok && (!s_dllp_axis.tvalid || burst_full);
    assign pick_dllp = s_dllp_axis.tvalid && !pick_tlp;

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: grant from IDLE, hold until the granted source's tlast transfers
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_tlp)       state_d = ST_TLP;
                else if (pick_dllp) state_d = ST_DLLP;
            end
            ST_DLLP: if (push && in_beat.last) state_d = ST_IDLE;
            ST_TLP:  if (push && in_beat.last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: only the granted source sees the buffer's ready. A TLP already
    // granted keeps streaming if the link drops so the packet is never truncated.
    always_comb begin
        s_tlp_axis.tready  = (state_q == ST_TLP)  && in_rdy;
        s_dllp_axis.tready = (state_q == ST_DLLP) && in_rdy;
    end

    // Source select and tuser tag rewrite (bit1 = TLP, bit0 = DLLP, upper bits pass)
    always_comb begin
        if (state_q == ST_TLP) begin
            in_beat = '{data: s_tlp_axis.tdata, keep: s_tlp_axis.tkeep,
                        last: s_tlp_axis.tlast, user: s_tlp_axis.tuser};
            in_vld  = s_tlp_axis.tvalid;
        end else begin
            in_beat = '{data: s_dllp_axis.tdata, keep: s_dllp_axis.tkeep,
                        last: s_dllp_axis.tlast, user: s_dllp_axis.tuser};
            in_vld  = s_dllp_axis.tvalid && (state_q == ST_DLLP);
        end
        in_beat.user[1] = (state_q == ST_TLP);
        in_beat.user[0] = (state_q != ST_TLP);
    end

    // Upstream ready depends only on the skid slot, so it is a clean registered signal
    assign in_rdy = !skid_vld_q;
    assign push   = in_vld && in_rdy;
    assign pop    = out_vld_q && m_axis.tready;

    // Skid next state: the skid slot absorbs the one beat accepted while the output stalls
    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (skid_vld_q) begin
            if (pop) begin
                out_d      = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (push) begin
            if (!out_vld_q || pop) begin
                out_d     = in_beat;
                out_vld_d = 1'b1;
            end else begin
                skid_d     = in_beat;
                skid_vld_d = 1'b1;
            end
        end else if (pop) begin
            out_vld_d = 1'b0;
        end
    end

    // Skid registers; reset drops any buffered beats
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign m_axis.tdata  = out_q.data;
    assign m_axis.tkeep  = out_q.keep;
    assign m_axis.tlast  = out_q.last;
    assign m_axis.tuser  = out_q.user;
    assign m_axis.tvalid = out_vld_q;

endmodule

// File: tb/tb_axis_user_mux.sv
// Self-checking bench for axis_user_mux: per-source expected-beat queues filled by the
// drivers, a negedge monitor that pops and compares every output transfer, plus
// packet-order / latency checks derived from the arbitration rules.

module tb_axis_user_mux;
    import axis_user_mux_pkg::*;

    localparam int DW   = 32;
    localparam int KW   = 4;
    localparam int UW   = 4;
    localparam int MAXB = 4;
`ifdef AXIS_USER_MUX_FAIR_ARB_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic            clk;
    logic            rst;
    pcie_dl_status_e link;

    axis_user_mux_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) tlp_if ();
    axis_user_mux_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) dllp_if ();
    axis_user_mux_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) m_if ();

    axis_user_mux #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .MAX_DLLP_BURST(MAXB)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .link_status_i (link),
        .s_tlp_axis    (tlp_if),
        .s_dllp_axis   (dllp_if),
        .m_axis        (m_if)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic [UW-1:0] u;
    } beat_t;

    beat_t exp_tlp[$];
    beat_t exp_dllp[$];
    bit    pkt_log[$];   // source of each output packet, 1 = TLP
    int    pkt_cyc[$];   // cycle at which each packet's first beat was on m_axis
    int    n_chk;
    int    n_fail;
    int    cyc;
    int    rmode;        // 0: ready high, 1: toggle, 2: random
    int    tmo;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (rmode)
            0:       m_if.tready = 1'b1;
            1:       m_if.tready = !m_if.tready;
            default: m_if.tready = ($urandom_range(0, 3) != 0);
        endcase
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, expv);
        end
    endtask

    // Output monitor: scoreboard pop, tag/atomicity, and hold-while-stalled checks
    initial begin
        bit    in_pkt, cur_t, prev_stall, is_t;
        beat_t prev, got, e;
        in_pkt = 0; cur_t = 0; prev_stall = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_pkt = 0;
                prev_stall = 0;
            end else begin
                got.d = m_if.tdata; got.k = m_if.tkeep; got.l = m_if.tlast; got.u = m_if.tuser;
                if (prev_stall) begin
                    chk("stall_valid", m_if.tvalid, 1'b1);
                    chk("stall_data", got.d, prev.d);
                    chk("stall_keep", got.k, prev.k);
                    chk("stall_last", got.l, prev.l);
                    chk("stall_user", got.u, prev.u);
                end
                if (m_if.tvalid && m_if.tready) begin
                    chk("tag_onehot", (got.u[1:0] == 2'b10) || (got.u[1:0] == 2'b01), 1'b1);
                    is_t = got.u[1];
                    if (in_pkt) chk("atomic", is_t, cur_t);
                    else begin
                        pkt_log.push_back(is_t);
                        pkt_cyc.push_back(cyc);
                    end
                    if ((is_t && exp_tlp.size() == 0) || (!is_t && exp_dllp.size() == 0)) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got data %0h user %0h required no beat", got.d, got.u);
                    end else begin
                        if (is_t) e = exp_tlp.pop_front();
                        else      e = exp_dllp.pop_front();
                        chk("beat_data", got.d, e.d);
                        chk("beat_keep", got.k, e.k);
                        chk("beat_last", got.l, e.l);
                        chk("beat_user", got.u, e.u);
                    end
                    in_pkt = !got.l;
                    cur_t  = is_t;
                end
                prev_stall = m_if.tvalid && !m_if.tready;
                prev = got;
            end
        end
    end

    // Drive one packet; called and returns at posedge+1. Aborts quietly on reset.
    task automatic send_pkt(input bit is_t, input int nb, input int gap_pct, output bit ok);
        beat_t b, e;
        bit    hs;
        int    w;
        ok = 1;
        for (int i = 0; i < nb; i++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                if (is_t) tlp_if.tvalid = 1'b0; else dllp_if.tvalid = 1'b0;
                @(posedge clk); #1;
            end
            b.d = $urandom; b.k = KW'($urandom); b.l = (i == nb - 1); b.u = UW'($urandom);
            e = b;
            e.u[1] = is_t;
            e.u[0] = !is_t;
            if (is_t) begin
                exp_tlp.push_back(e);
                tlp_if.tdata = b.d; tlp_if.tkeep = b.k; tlp_if.tlast = b.l;
                tlp_if.tuser = b.u; tlp_if.tvalid = 1'b1;
            end else begin
                exp_dllp.push_back(e);
                dllp_if.tdata = b.d; dllp_if.tkeep = b.k; dllp_if.tlast = b.l;
                dllp_if.tuser = b.u; dllp_if.tvalid = 1'b1;
            end
            hs = 0; w = 0;
            while (!hs) begin
                @(negedge clk);
                if (rst) begin ok = 0; break; end
                hs = is_t ? tlp_if.tready : dllp_if.tready;
                @(posedge clk); #1;
                w++;
                if (!hs && w > tmo) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL handshake_timeout: src_tlp=%0d beat %0d got no tready in %0d cycles required tready", is_t, i, w);
                    tmo = 20;
                    ok = 0;
                    break;
                end
            end
            if (!ok) break;
        end
        if (is_t) tlp_if.tvalid = 1'b0; else dllp_if.tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((exp_tlp.size() != 0 || exp_dllp.size() != 0 || m_if.tvalid) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 1000) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d tlp / %0d dllp beats outstanding required 0",
                     exp_tlp.size(), exp_dllp.size());
            exp_tlp.delete();
            exp_dllp.delete();
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic clear_log();
        pkt_log.delete();
        pkt_cyc.delete();
    endtask

    initial begin
        bit ok1, ok2;
        int t0, idx, w;
        n_chk = 0; n_fail = 0; cyc = 0; rmode = 0; tmo = 500;
        link = DL_ACTIVE;
        m_if.tready = 1'b0;
        tlp_if.tdata = '0; tlp_if.tkeep = '0; tlp_if.tlast = 1'b0; tlp_if.tuser = '0;
        dllp_if.tdata = '0; dllp_if.tkeep = '0; dllp_if.tlast = 1'b0; dllp_if.tuser = '0;
        // Sources valid during reset: both readies must still be held low
        tlp_if.tvalid = 1'b1; dllp_if.tvalid = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_m_tvalid", m_if.tvalid, 1'b0);
        chk("reset_tlp_tready", tlp_if.tready, 1'b0);
        chk("reset_dllp_tready", dllp_if.tready, 1'b0);
        tlp_if.tvalid = 1'b0; dllp_if.tvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Single 3-beat TLP: first output two cycles after the decision cycle
        clear_log();
        t0 = cyc;
        send_pkt(1'b1, 3, 0, ok1);
        wait_drain();
        chk("single_tlp_npkt", pkt_log.size(), 1);
        if (pkt_cyc.size() > 0) chk("single_tlp_latency", pkt_cyc[0] - t0, 2);

        // DLLP and TLP valid together: DLLP packet first
        clear_log();
        fork
            send_pkt(1'b0, 2, 0, ok1);
            send_pkt(1'b1, 3, 0, ok2);
        join
        wait_drain();
        chk("tie_npkt", pkt_log.size(), 2);
        if (pkt_log.size() == 2) begin
            chk("tie_first_dllp", pkt_log[0], 1'b0);
            chk("tie_second_tlp", pkt_log[1], 1'b1);
        end

        // Toggling output ready during a 4-beat TLP
        clear_log();
        rmode = 1;
        send_pkt(1'b1, 4, 0, ok1);
        wait_drain();
        rmode = 0;
        chk("toggle_npkt", pkt_log.size(), 1);

        // Back-to-back DLLPs with a waiting TLP
        clear_log();
        fork
            begin
                for (int i = 0; i < 8; i++) send_pkt(1'b0, $urandom_range(1, 2), 0, ok1);
            end
            send_pkt(1'b1, 2, 0, ok2);
        join
        wait_drain();
        idx = -1;
        foreach (pkt_log[i]) if (pkt_log[i] && idx < 0) idx = i;
        chk("burst_tlp_position", idx, FAIR ? MAXB : 8);

        // Link down: TLP held off, DLLPs still flow, TLP goes once the link is up
        clear_log();
        link = DL_INIT;
        fork
            send_pkt(1'b1, 2, 0, ok2);
            begin
                repeat (6) begin
                    @(negedge clk);
                    chk("linkdown_tlp_tready", tlp_if.tready, 1'b0);
                    chk("linkdown_m_tvalid", m_if.tvalid, 1'b0);
                end
                @(posedge clk); #1;
                send_pkt(1'b0, 2, 0, ok1);
                repeat (4) begin
                    @(negedge clk);
                    chk("linkdown_tlp_tready2", tlp_if.tready, 1'b0);
                end
                @(posedge clk); #1;
                link = DL_ACTIVE;
            end
        join
        wait_drain();
        chk("linkdown_npkt", pkt_log.size(), 2);
        if (pkt_log.size() == 2) begin
            chk("linkdown_first_dllp", pkt_log[0], 1'b0);
            chk("linkdown_then_tlp", pkt_log[1], 1'b1);
        end

        // Link drops mid-TLP: packet completes, next TLP waits for the link
        clear_log();
        fork
            send_pkt(1'b1, 4, 0, ok1);
            begin
                w = 0;
                do begin @(negedge clk); w++; end
                while (!(tlp_if.tvalid && tlp_if.tready) && w < 100);
                @(posedge clk); #1;
                link = DL_INIT;
            end
        join
        fork
            send_pkt(1'b1, 1, 0, ok2);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("linkdrop_block", tlp_if.tready, 1'b0);
                end
                @(posedge clk); #1;
                link = DL_ACTIVE;
            end
        join
        wait_drain();
        chk("linkdrop_npkt", pkt_log.size(), 2);

        // Reset while beat 2 of a 4-beat TLP is on the output
        clear_log();
        fork
            send_pkt(1'b1, 4, 0, ok1);
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("rstmid_pre_valid", m_if.tvalid, 1'b1);
                rst = 1'b1;
                #1;
                chk("rstmid_m_tvalid", m_if.tvalid, 1'b0);
                chk("rstmid_tlp_tready", tlp_if.tready, 1'b0);
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
            end
        join
        exp_tlp.delete();
        exp_dllp.delete();
        @(posedge clk); #1;
        clear_log();
        send_pkt(1'b0, 2, 0, ok1);
        wait_drain();
        chk("rstmid_npkt", pkt_log.size(), 1);
        if (pkt_log.size() == 1) chk("rstmid_new_dllp", pkt_log[0], 1'b0);

        // Random traffic on both sources with random output backpressure
        clear_log();
        rmode = 2;
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    send_pkt(1'b1, $urandom_range(1, 5), 20, ok1);
                end
            end
            begin
                for (int j = 0; j < 25; j++) begin
                    repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
                    send_pkt(1'b0, $urandom_range(1, 3), 20, ok2);
                end
            end
        join
        wait_drain();
        rmode = 0;
        chk("random_npkt", pkt_log.size(), 50);
        chk("queues_empty", exp_tlp.size() + exp_dllp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
